snake_engine: RTL
=================

SNAKE_ENGINE -- requirements
Module: snake_engine

Interface
REQ-001 SHALL have parameter XSIZE, default 48: grid width in cells.
REQ-002 SHALL have parameter YSIZE, default 64: grid height in cells.
REQ-003 SHALL have parameter CW, default 6: coordinate width.
REQ-004 SHALL have parameter MAX_LEN, default 32: body buffer depth.
REQ-005 SHALL have parameter TICK_MAX, default 25_000_000: tick accumulator threshold.
REQ-006 SHALL have parameter DEF_SPD, default 2: speed after reset and after boost expiry.
REQ-007 SHALL have parameter MAX_SPD, default 31: speed saturation value.
REQ-008 SHALL have parameter BOOST_MOVES, default 16: moves before speed reverts.
REQ-009 SHALL have parameter DEF_LEN, default 3: initial length, 2..MAX_LEN.
REQ-010 SHALL have parameter WRAP, default 0: 0 = wall kills; 1 = toroidal wrap.
REQ-011 SHALL have ports:
- i_Clk  in  1  clock.
- i_Rst  in  1  asynchronous, active-low reset.
- i_Start  in  1  start or restart request.
- i_Pause  in  1  level pause request.
- i_Push  in  4  active-low direction buttons; bit0 = up (y-1), bit1 = down, bit2 = left, bit3 = right; lowest index wins.
- i_Item_Vld  in  1  item generator response valid.
- i_Item_x, i_Item_y  in  CW each  offered item position.
- o_Item_Req  out  1  item request.
- i_Rd_Idx  in  clog2(MAX_LEN)  render read index; 0 = head.
- o_Rd_x, o_Rd_y  out  CW each  segment at i_Rd_Idx, registered, 1-cycle latency.
- o_Head_x, o_Head_y, o_Item_x, o_Item_y  out  CW each  current positions.
- o_Len  out  clog2(MAX_LEN+1)  current length.
- o_Score  out  12  score.
- o_Speed  out  5  current speed.
- o_State  out  3  FSM state.
- o_Step  out  1  one-cycle pulse on each committed move.
- o_Over  out  1  game over.

Function
REQ-012 SHALL implement FSM IDLE, RUN, MOVE, CHECK, COMMIT, ITEM, PAUSE, OVER with the transitions in REQ-013..REQ-021.
REQ-013 IDLE -> RUN on i_Start.
REQ-014 In RUN, the accumulator SHALL add o_Speed each cycle; when accumulator >= TICK_MAX it SHALL clear and the FSM SHALL go to MOVE.
REQ-015 In RUN, i_Pause SHALL take priority over the tick: go to PAUSE with the accumulator frozen; PAUSE -> RUN when i_Pause is low. i_Pause SHALL be ignored in all other states.
REQ-016 A direction push SHALL be latched in any state except OVER; a push opposite to the last moved direction SHALL be discarded.
REQ-017 In MOVE, the next head SHALL be computed from the latched direction. WRAP=0: a next head on row/column 0 or SIZE-1 SHALL go to OVER. WRAP=1: coordinates SHALL wrap modulo XSIZE/YSIZE.
REQ-018 eat SHALL equal (next head == item).
REQ-019 CHECK SHALL compare the next head against one segment per cycle, indices 0..o_Len-2, plus index o_Len-1 when eat. A hit SHALL abort the scan immediately and go to OVER; otherwise the FSM SHALL go to COMMIT.
REQ-020 COMMIT SHALL advance the circular head pointer, write the new head and pulse o_Step. On eat: length +1 (saturates at MAX_LEN), score += max(1, speed>>1) (saturates at 4095), speed +1 (saturates at MAX_SPD), boost counter clears, and FSM goes to ITEM. Otherwise FSM goes to RUN.
REQ-021 Each non-eat COMMIT SHALL increment the boost counter; at BOOST_MOVES, speed SHALL revert to DEF_SPD and the counter SHALL clear.
REQ-022 In ITEM, o_Item_Req SHALL be held high until i_Item_Vld. An offer equal to the head, or on the border when WRAP=0, SHALL be rejected with the request kept high. An accepted offer SHALL load the item and return the FSM to RUN.
REQ-023 OVER SHALL hold o_Over=1 and freeze all state; i_Start SHALL reinitialise to reset values and go to IDLE.

Reset
REQ-024 Asserting i_Rst at any time, including mid-CHECK or mid-ITEM, SHALL load the following and clear any pending request:
- state IDLE, accumulator 0, speed DEF_SPD, score 0, length DEF_LEN, direction right.
- segment k at (XSIZE/2-k, YSIZE/2).
- item at (XSIZE/4, YSIZE/2).
- o_Item_Req=0, o_Step=0, o_Over=0, o_Rd_x/o_Rd_y=0.

Structure
REQ-025 Shared package snake_pkg SHALL hold the state encodings and direction codes (0 up, 1 down, 2 left, 3 right).
REQ-026 The body store SHALL be sub-module snake_body_ram: MAX_LEN x 2·CW circular buffer with one write port, one scan read port and one render read port.

Verification (XSIZE=YSIZE=16, MAX_LEN=8, TICK_MAX=4, DEF_SPD=2)
REQ-027 Reset, then i_Start, no push -> o_Step pulses; head goes (8,8) -> (9,8) -> (10,8).
REQ-028 Moving right, i_Push=4'b1011 (left) -> ignored, next head (x+1, 8); then i_Push=4'b1110 -> next head (x, 7).
REQ-029 Item (9,8), head (8,8) -> after step o_Len 3->4, score 1, speed 3, o_Item_Req=1; offer (9,8) rejected; offer (2,2) accepted -> item (2,2), req 0.
REQ-030 WRAP=0, head (14,8) moving right -> OVER, o_Over=1, head unchanged. WRAP=1, head (15,8) -> (0,8).
REQ-031 Length 5, pushes up, left, down on successive ticks -> self-hit in CHECK -> OVER.
REQ-032 i_Pause mid-RUN -> accumulator and head frozen; release resumes. i_Rst during ITEM -> reset values, o_Item_Req=0.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared definitions for the snake engine: FSM state encoding, direction
// codes and a direction helper.
package snake_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_MOVE   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_COMMIT = 3'd4,
    ST_ITEM   = 3'd5,
    ST_PAUSE  = 3'd6,
    ST_OVER   = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  // Opposite pairs differ only in bit 0 (up/down = 0/1, left/right = 2/3).
  function automatic logic is_opposite(input dir_t a, input dir_t b);
    logic [1:0] d;
    d = a ^ b;
    return d == 2'b01;
  endfunction

endpackage

// File: rtl/snake_body_ram.sv
// Circular body store for the snake engine.
//   i_Clk, i_Rst        : clock, asynchronous active-low reset
//   i_Init              : synchronous reload of the starting body
//   i_We/i_Waddr/i_Wx/y : single write port
//   i_Scan_Addr -> o_Scan_x/y : combinational read for collision scan
//   i_Rd_Addr   -> o_Rd_x/y   : registered read for rendering (1 cycle)
// After (re)initialisation physical entry k holds segment k, i.e. the
// starting body lies along row YSIZE/2 extending left from the centre.
module snake_body_ram
  import snake_pkg::*;
#(
  parameter int CW      = 6,
  parameter int MAX_LEN = 32,
  parameter int XSIZE   = 48,
  parameter int YSIZE   = 64,
  parameter int AW      = $clog2(MAX_LEN)
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  input  logic          i_Init,
  input  logic          i_We,
  input  logic [AW-1:0] i_Waddr,
  input  logic [CW-1:0] i_Wx,
  input  logic [CW-1:0] i_Wy,
  input  logic [AW-1:0] i_Scan_Addr,
  output logic [CW-1:0] o_Scan_x,
  output logic [CW-1:0] o_Scan_y,
  input  logic [AW-1:0] i_Rd_Addr,
  output logic [CW-1:0] o_Rd_x,
  output logic [CW-1:0] o_Rd_y
);

  logic [CW-1:0] mem_x [MAX_LEN];
  logic [CW-1:0] mem_y [MAX_LEN];

  assign o_Scan_x = mem_x[i_Scan_Addr];
  assign o_Scan_y = mem_y[i_Scan_Addr];

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      for (int unsigned k = 0; k < MAX_LEN; k++) begin
        mem_x[k] <= CW'(XSIZE / 2) - CW'(k);
        mem_y[k] <= CW'(YSIZE / 2);
      end
      o_Rd_x <= '0;
      o_Rd_y <= '0;
    end else if (i_Init) begin
      for (int unsigned k = 0; k < MAX_LEN; k++) begin
        mem_x[k] <= CW'(XSIZE / 2) - CW'(k);
        mem_y[k] <= CW'(YSIZE / 2);
      end
      o_Rd_x <= '0;
      o_Rd_y <= '0;
    end else begin
      if (i_We) begin
        mem_x[i_Waddr] <= i_Wx;
        mem_y[i_Waddr] <= i_Wy;
      end
      o_Rd_x <= mem_x[i_Rd_Addr];
      o_Rd_y <= mem_y[i_Rd_Addr];
    end
  end

endmodule

// File: rtl/snake_engine.sv
// Snake game engine: tick generation, direction latching, move/collision
// sequencing, growth/score/speed bookkeeping and item handshake.
//   i_Clk, i_Rst       : clock, asynchronous active-low reset
//   i_Start, i_Pause   : start/restart request, level pause
//   i_Push             : active-low buttons {right,left,down,up}
//   i_Item_Vld/x/y     : item offer;  o_Item_Req : item wanted
//   i_Rd_Idx -> o_Rd_x/y : body segment read (0 = head), 1-cycle latency
//   o_Head_*, o_Item_*, o_Len, o_Score, o_Speed, o_State, o_Step, o_Over
module snake_engine
  import snake_pkg::*;
#(
  parameter int XSIZE       = 48,
  parameter int YSIZE       = 64,
  parameter int CW          = 6,
  parameter int MAX_LEN     = 32,
  parameter int TICK_MAX    = 25_000_000,
  parameter int DEF_SPD     = 2,
  parameter int MAX_SPD     = 31,
  parameter int BOOST_MOVES = 16,
  parameter int DEF_LEN     = 3,
  parameter int WRAP        = 0
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst,
  input  logic                         i_Start,
  input  logic                         i_Pause,
  input  logic [3:0]                   i_Push,
  input  logic                         i_Item_Vld,
  input  logic [CW-1:0]                i_Item_x,
  input  logic [CW-1:0]                i_Item_y,
  output logic                         o_Item_Req,
  input  logic [$clog2(MAX_LEN)-1:0]   i_Rd_Idx,
  output logic [CW-1:0]                o_Rd_x,
  output logic [CW-1:0]                o_Rd_y,
  output logic [CW-1:0]                o_Head_x,
  output logic [CW-1:0]                o_Head_y,
  output logic [CW-1:0]                o_Item_x,
  output logic [CW-1:0]                o_Item_y,
  output logic [$clog2(MAX_LEN+1)-1:0] o_Len,
  output logic [11:0]                  o_Score,
  output logic [4:0]                   o_Speed,
  output logic [2:0]                   o_State,
  output logic                         o_Step,
  output logic                         o_Over
);

  localparam int unsigned AW  = $clog2(MAX_LEN);
  localparam int unsigned LW  = $clog2(MAX_LEN + 1);
  localparam int unsigned AW1 = AW + 1;

  state_t        state, state_nxt;
  logic [31:0]   acc;
  logic [4:0]    speed;
  logic [11:0]   score;
  logic [LW-1:0] len;
  logic [15:0]   boost;
  dir_t          dir_pend, dir_last, mv_dir;
  logic [CW-1:0] head_x, head_y, item_x, item_y;
  logic [CW-1:0] nxt_x, nxt_y;
  logic          eat;
  logic [AW-1:0] hp, scan_i;
  logic          step_q;

  // Logical segment k lives at physical (hp + k) mod MAX_LEN; a move
  // decrements hp so the old body keeps its physical slots.
  function automatic logic [AW-1:0] ring_add(input logic [AW-1:0] a,
                                             input logic [AW-1:0] b);
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= AW1'(MAX_LEN)) s = s - AW1'(MAX_LEN);
    return s[AW-1:0];
  endfunction

  function automatic logic on_border(input logic [CW-1:0] x,
                                     input logic [CW-1:0] y);
    return (x == '0) || (x == CW'(XSIZE - 1)) ||
           (y == '0) || (y == CW'(YSIZE - 1));
  endfunction

  // Tick accumulator
  logic [32:0] acc_sum;
  logic        tick;
  assign acc_sum = {1'b0, acc} + 33'(speed);
  assign tick    = acc_sum >= 33'(TICK_MAX);

  // Direction buttons: lowest pressed index wins
  logic push_vld, push_take;
  dir_t push_dir;
  always_comb begin
    push_vld = 1'b1;
    push_dir = DIR_RIGHT;
    if (!i_Push[0])      push_dir = DIR_UP;
    else if (!i_Push[1]) push_dir = DIR_DOWN;
    else if (!i_Push[2]) push_dir = DIR_LEFT;
    else if (!i_Push[3]) push_dir = DIR_RIGHT;
    else                 push_vld = 1'b0;
  end
  assign push_take = push_vld && (state != ST_OVER) &&
                     !is_opposite(push_dir, dir_last);

  // Candidate head; computed with wrap in both modes, the border check
  // below decides whether a wall is fatal.
  logic [CW-1:0] cand_x, cand_y;
  logic          cand_kill, cand_eat;
  always_comb begin
    cand_x = head_x;
    cand_y = head_y;
    case (dir_pend)
      DIR_UP:   cand_y = (head_y == '0) ? CW'(YSIZE - 1) : head_y - 1'b1;
      DIR_DOWN: cand_y = (head_y == CW'(YSIZE - 1)) ? '0 : head_y + 1'b1;
      DIR_LEFT: cand_x = (head_x == '0) ? CW'(XSIZE - 1) : head_x - 1'b1;
      default:  cand_x = (head_x == CW'(XSIZE - 1)) ? '0 : head_x + 1'b1;
    endcase
  end
  assign cand_kill = (WRAP == 0) && on_border(cand_x, cand_y);
  assign cand_eat  = (cand_x == item_x) && (cand_y == item_y);

  // Collision scan; the tail is only included when it will not move away
  logic [CW-1:0] scan_x, scan_y, rd_x, rd_y;
  logic [AW-1:0] scan_addr, rd_addr, hp_dec;
  logic [LW-1:0] scan_lim;
  logic          scan_hit, scan_end;
  assign scan_addr = ring_add(hp, scan_i);
  assign rd_addr   = ring_add(hp, i_Rd_Idx);
  assign hp_dec    = (hp == '0) ? AW'(MAX_LEN - 1) : hp - 1'b1;
  assign scan_lim  = eat ? len - 1'b1 : len - 2'd2;
  assign scan_hit  = (scan_x == nxt_x) && (scan_y == nxt_y);
  assign scan_end  = LW'(scan_i) == scan_lim;

  // Item offer filter
  logic offer_ok;
  assign offer_ok = !(((i_Item_x == head_x) && (i_Item_y == head_y)) ||
                      ((WRAP == 0) && on_border(i_Item_x, i_Item_y)));

  // Growth bookkeeping
  logic [11:0] score_inc;
  logic [12:0] score_sum;
  assign score_inc = (speed[4:1] == '0) ? 12'd1 : 12'(speed[4:1]);
  assign score_sum = 13'(score) + 13'(score_inc);

  logic restart;
  assign restart = (state == ST_OVER) && i_Start;

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (i_Start) state_nxt = ST_RUN;
      ST_RUN:    if (i_Pause) state_nxt = ST_PAUSE;
                 else if (tick) state_nxt = ST_MOVE;
      ST_MOVE:   state_nxt = cand_kill ? ST_OVER : ST_CHECK;
      ST_CHECK:  if (scan_hit) state_nxt = ST_OVER;
                 else if (scan_end) state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = eat ? ST_ITEM : ST_RUN;
      ST_ITEM:   if (i_Item_Vld && offer_ok) state_nxt = ST_RUN;
      ST_PAUSE:  if (!i_Pause) state_nxt = ST_RUN;
      ST_OVER:   if (i_Start) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      acc      <= '0;
      speed    <= 5'(DEF_SPD);
      score    <= '0;
      len      <= LW'(DEF_LEN);
      boost    <= '0;
      dir_pend <= DIR_RIGHT;
      dir_last <= DIR_RIGHT;
      mv_dir   <= DIR_RIGHT;
      head_x   <= CW'(XSIZE / 2);
      head_y   <= CW'(YSIZE / 2);
      item_x   <= CW'(XSIZE / 4);
      item_y   <= CW'(YSIZE / 2);
      nxt_x    <= '0;
      nxt_y    <= '0;
      eat      <= 1'b0;
      hp       <= '0;
      scan_i   <= '0;
      step_q   <= 1'b0;
    end else if (restart) begin
      acc      <= '0;
      speed    <= 5'(DEF_SPD);
      score    <= '0;
      len      <= LW'(DEF_LEN);
      boost    <= '0;
      dir_pend <= DIR_RIGHT;
      dir_last <= DIR_RIGHT;
      mv_dir   <= DIR_RIGHT;
      head_x   <= CW'(XSIZE / 2);
      head_y   <= CW'(YSIZE / 2);
      item_x   <= CW'(XSIZE / 4);
      item_y   <= CW'(YSIZE / 2);
      nxt_x    <= '0;
      nxt_y    <= '0;
      eat      <= 1'b0;
      hp       <= '0;
      scan_i   <= '0;
      step_q   <= 1'b0;
    end else begin
      step_q <= 1'b0;
      if (push_take) dir_pend <= push_dir;
      case (state)
        ST_RUN: if (!i_Pause) acc <= tick ? '0 : acc_sum[31:0];
        ST_MOVE: begin
          nxt_x  <= cand_x;
          nxt_y  <= cand_y;
          eat    <= cand_eat;
          mv_dir <= dir_pend;
          scan_i <= '0;
        end
        ST_CHECK: scan_i <= scan_i + 1'b1;
        ST_COMMIT: begin
          hp       <= hp_dec;
          head_x   <= nxt_x;
          head_y   <= nxt_y;
          dir_last <= mv_dir;
          step_q   <= 1'b1;
          if (eat) begin
            if (len != LW'(MAX_LEN)) len <= len + 1'b1;
            score <= (score_sum > 13'd4095) ? 12'hFFF : score_sum[11:0];
            if (speed != 5'(MAX_SPD)) speed <= speed + 1'b1;
            boost <= '0;
          end else if ((boost + 16'd1) >= 16'(BOOST_MOVES)) begin
            speed <= 5'(DEF_SPD);
            boost <= '0;
          end else begin
            boost <= boost + 16'd1;
          end
        end
        ST_ITEM: if (i_Item_Vld && offer_ok) begin
          item_x <= i_Item_x;
          item_y <= i_Item_y;
        end
        default: ;
      endcase
    end
  end

  snake_body_ram #(
    .CW      (CW),
    .MAX_LEN (MAX_LEN),
    .XSIZE   (XSIZE),
    .YSIZE   (YSIZE),
    .AW      (AW)
  ) u_body (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_Init      (restart),
    .i_We        (state == ST_COMMIT),
    .i_Waddr     (hp_dec),
    .i_Wx        (nxt_x),
    .i_Wy        (nxt_y),
    .i_Scan_Addr (scan_addr),
    .o_Scan_x    (scan_x),
    .o_Scan_y    (scan_y),
    .i_Rd_Addr   (rd_addr),
    .o_Rd_x      (rd_x),
    .o_Rd_y      (rd_y)
  );

  assign o_Rd_x     = rd_x;
  assign o_Rd_y     = rd_y;
  assign o_Head_x   = head_x;
  assign o_Head_y   = head_y;
  assign o_Item_x   = item_x;
  assign o_Item_y   = item_y;
  assign o_Len      = len;
  assign o_Score    = score;
  assign o_Speed    = speed;
  assign o_State    = state;
  assign o_Step     = step_q;
  assign o_Over     = (state == ST_OVER);
  assign o_Item_Req = (state == ST_ITEM);

endmodule
